// File: rtl/mem_ctrl_pkg.sv
// Shared widths, length codes and controller state encoding for mem_ctrl.
// No logic of its own; imported by the controller.
// Length helper maps the 2-bit length code to a byte count.
package mem_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b10;

    typedef enum logic [1:0] {
        McIdle  = 2'd0,
        McFetch = 2'd1,
        McLoad  = 2'd2,
        McStore = 2'd3
    } mc_state_t;

    // Number of RAM byte accesses for a data-port length code; 11 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LenByte:        return 3'd1;
            LenHalf:        return 3'd2;
            LenWord, 2'b11: return 3'd4;
            default:        return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Purpose: single-port controller serialising IF fetches and MEM loads/stores onto a byte-wide RAM.
// Latency: read of n bytes completes n+2 cycles after accept, store of n bytes n+1 cycles after accept.
// Backpressure: requesters hold req until their done pulse; data port wins contention, fetch may be aborted.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    input  logic                   if_abort_i,
    output logic                   if_done_o,
    output logic [InstBus-1:0]     if_inst_o,
    input  logic                   mem_req_i,
    input  logic                   mem_we_i,
    input  logic [InstAddrBus-1:0] mem_addr_i,
    input  logic [InstBus-1:0]     mem_wdata_i,
    input  logic [1:0]             mem_len_i,
    output logic                   mem_done_o,
    output logic [InstBus-1:0]     mem_rdata_o,
    output logic [InstAddrBus-1:0] ram_addr_o,
    output logic [7:0]             ram_dout_o,
    output logic                   ram_we_o,
    input  logic [7:0]             ram_din_i
);

    mc_state_t              state;
    mc_state_t              state_nxt;
    logic [InstAddrBus-1:0] base;
    logic [2:0]             len_n;
    logic [InstBus-1:0]     wdata;
    logic [2:0]             cnt;
    logic [2:0]             cap;
    logic [InstBus-1:0]     asm_q;
    logic [InstBus-1:0]     asm_nxt;
    logic                   idle_ok;
    logic                   accept_mem;
    logic                   accept_if;
    logic                   reading;
    logic                   capture;
    logic                   last_cap;
    logic                   store_last;

    // Request acceptance and per-cycle sequencing conditions.
    always_comb begin
        idle_ok    = (state == McIdle) && !if_done_o && !mem_done_o;
        accept_mem = idle_ok && mem_req_i;
        accept_if  = idle_ok && !mem_req_i && if_req_i && !if_abort_i;
        reading    = (state == McFetch) || (state == McLoad);
        // A lane is pending whenever more addresses were issued than bytes captured.
        capture    = reading && (cap != cnt);
        last_cap   = capture && (cap == len_n - 3'd1);
        store_last = (state == McStore) && (cnt == len_n - 3'd1);
    end

    // Next-state selection; abort only cancels a fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            McIdle: begin
                if (accept_mem) begin
                    state_nxt = mem_we_i ? McStore : McLoad;
                end else if (accept_if) begin
                    state_nxt = McFetch;
                end
            end
            McFetch: begin
                if (if_abort_i || last_cap) begin
                    state_nxt = McIdle;
                end
            end
            McLoad: begin
                if (last_cap) begin
                    state_nxt = McIdle;
                end
            end
            McStore: begin
                if (store_last) begin
                    state_nxt = McIdle;
                end
            end
            default: state_nxt = McIdle;
        endcase
    end

    // Merge the RAM byte into the assembly register at the capture lane.
    always_comb begin
        asm_nxt = asm_q;
        if (capture) begin
            case (cap[1:0])
                2'd0:    asm_nxt[7:0]   = ram_din_i;
                2'd1:    asm_nxt[15:8]  = ram_din_i;
                2'd2:    asm_nxt[23:16] = ram_din_i;
                default: asm_nxt[31:24] = ram_din_i;
            endcase
        end
    end

    // RAM side: address follows the issue counter, writes only in STORE and never during reset.
    always_comb begin
        ram_addr_o = ZeroWord;
        ram_dout_o = 8'h00;
        ram_we_o   = (state == McStore) && !rst;
        if (state != McIdle) begin
            ram_addr_o = base + {29'd0, cnt};
        end
        if (state == McStore) begin
            case (cnt[1:0])
                2'd0:    ram_dout_o = wdata[7:0];
                2'd1:    ram_dout_o = wdata[15:8];
                2'd2:    ram_dout_o = wdata[23:16];
                default: ram_dout_o = wdata[31:24];
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= McIdle;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, issue/capture counters and the assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base  <= ZeroWord;
            len_n <= 3'd0;
            wdata <= ZeroWord;
            cnt   <= 3'd0;
            cap   <= 3'd0;
            asm_q <= ZeroWord;
        end else if (accept_mem || accept_if) begin
            base  <= accept_mem ? mem_addr_i : if_addr_i;
            len_n <= accept_mem ? len_bytes(mem_len_i) : 3'd4;
            wdata <= accept_mem ? mem_wdata_i : ZeroWord;
            cnt   <= 3'd0;
            cap   <= 3'd0;
            asm_q <= ZeroWord;
        end else if (state != McIdle) begin
            if (cnt < len_n) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                cap   <= cap + 3'd1;
                asm_q <= asm_nxt;
            end
        end
    end

    // Result registers and one-cycle done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_done_o   <= 1'b0;
            if_inst_o   <= ZeroWord;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= ZeroWord;
        end else begin
            if_done_o  <= (state == McFetch) && !if_abort_i && last_cap;
            mem_done_o <= ((state == McLoad) && last_cap) || store_last;
            if ((state == McFetch) && !if_abort_i && last_cap) begin
                if_inst_o <= asm_nxt;
            end
            if ((state == McLoad) && last_cap) begin
                mem_rdata_o <= asm_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, directed vector table, corner sequences, random ops vs reference.
// Latency is counted in cycles from the accepting cycle.
// Requests are held until done, mirroring the pipeline stages.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_abort = 1'b0;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [1:0]  mem_len = 2'b00;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_dout_o;
    logic        ram_we_o;
    logic [7:0]  ram_din = 8'h00;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] addr_log [0:15];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          op;        // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
        int          exp_lat;
        logic [31:0] exp_data;
        int          exp_mask;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_abort_i  (if_abort),
        .if_done_o   (if_done_o),
        .if_inst_o   (if_inst_o),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_len_i   (mem_len),
        .mem_done_o  (mem_done_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_we_o    (ram_we_o),
        .ram_din_i   (ram_din)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    // Byte RAM: write on the edge, read data registered one cycle after its address.
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_addr_o] = ram_dout_o;
        ram_din <= ram_rd(ram_addr_o);
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one request at the current cycle T and follow it to its done pulse.
    task automatic run_req(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] len, output int lat, output logic [31:0] data,
                           output int we_mask, output logic pulse_ok);
        lat = -1;
        data = 32'h0;
        we_mask = 0;
        pulse_ok = 1'b0;
        if (op == 0) begin
            if_req = 1'b1;
            if_addr = addr;
        end else begin
            mem_req = 1'b1;
            mem_we = (op == 2);
            mem_addr = addr;
            mem_wdata = wdata;
            mem_len = len;
        end
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c < 16) addr_log[c] = ram_addr_o;
            if (ram_we_o) we_mask = we_mask | (1 << c);
            if ((op == 0 && if_done_o) || (op != 0 && mem_done_o)) begin
                lat = c;
                data = (op == 0) ? if_inst_o : mem_rdata_o;
                break;
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        step();
        pulse_ok = !if_done_o && !mem_done_o;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          mask;
        logic [31:0] data;
        logic        pulse_ok;
        int          mem_done_at;
        int          if_done_at;
        logic [31:0] mem_got;
        logic [31:0] a5;
        logic        seen_done;
        int          mism;

        vecs[0] = '{0, 32'h0000_0100, 32'h0,         2'b10, 6, 32'h0000_0513, 0};
        vecs[1] = '{1, 32'h0000_0020, 32'h0,         2'b00, 3, 32'h0000_00F0, 0};
        vecs[2] = '{1, 32'h0000_0101, 32'h0,         2'b01, 4, 32'h0000_0005, 0};
        vecs[3] = '{1, 32'h0000_0100, 32'h0,         2'b11, 6, 32'h0000_0513, 0};
        vecs[4] = '{2, 32'h0000_0203, 32'hDEADBEEF,  2'b01, 3, 32'h0,         32'h6};
        vecs[5] = '{2, 32'h0000_0210, 32'h12345678,  2'b00, 2, 32'h0,         32'h2};
        vecs[6] = '{1, 32'h0000_0203, 32'h0,         2'b10, 6, 32'h0000_BEEF, 0};
        vecs[7] = '{2, 32'h0000_0220, 32'hCAFEF00D,  2'b10, 5, 32'h0,         32'h1E};
        vecs[8] = '{1, 32'h0000_0220, 32'h0,         2'b10, 6, 32'hCAFEF00D,  0};
        vecs[9] = '{1, 32'h0000_0221, 32'h0,         2'b01, 4, 32'h0000_FEF0, 0};

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h104, 8'h93); preload(32'h105, 8'h05);
        preload(32'h106, 8'h10); preload(32'h107, 8'h00);
        preload(32'h020, 8'hF0);
        preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0000_0000, 8'h33); preload(32'h0000_0001, 8'h44);
        for (int i = 0; i < 4; i++) preload(32'h300 + 32'(i), 8'hAA);

        // Reset state.
        step(); step();
        rst = 1'b0;
        step();
        check("rst_if_done",   {31'd0, if_done_o},  32'h0);
        check("rst_if_inst",   if_inst_o,           32'h0);
        check("rst_mem_done",  {31'd0, mem_done_o}, 32'h0);
        check("rst_mem_rdata", mem_rdata_o,         32'h0);
        check("rst_ram_addr",  ram_addr_o,          32'h0);
        check("rst_ram_we",    {31'd0, ram_we_o},   32'h0);
        check("rst_ram_dout",  {24'd0, ram_dout_o}, 32'h0);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].len, lat, data, mask, pulse_ok);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_cycles", i), 32'(mask), 32'(vecs[i].exp_mask));
            check($sformatf("vec%0d_pulse", i), {31'd0, pulse_ok}, 32'h1);
            if (vecs[i].op != 2) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
        end
        check("half_store_b0", {24'd0, ram_rd(32'h203)}, 32'hEF);
        check("half_store_b1", {24'd0, ram_rd(32'h204)}, 32'hBE);
        check("byte_store",    {24'd0, ram_rd(32'h210)}, 32'h78);

        // Contention: both requests rise together, data port first.
        mem_done_at = -1; if_done_at = -1; mem_got = 32'h0; a5 = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mem_len = 2'b00;
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 5) a5 = ram_addr_o;
            if (mem_done_o) begin
                mem_done_at = c;
                mem_got = mem_rdata_o;
                mem_req = 1'b0;
            end
            if (if_done_o) begin
                if_done_at = c;
                break;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();
        check("cont_mem_done_cycle", 32'(mem_done_at), 32'd3);
        check("cont_mem_rdata",      mem_got,          32'h0000_00F0);
        check("cont_fetch_addr_t5",  a5,               32'h0000_0100);
        check("cont_if_done_cycle",  32'(if_done_at),  32'd10);

        // Abort a fetch at T+3, then a new fetch from T+4.
        seen_done = 1'b0; if_done_at = -1;
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (if_done_o) seen_done = 1'b1;
            if (c == 3) if_abort = 1'b1;
            if (c == 4) begin
                if_abort = 1'b0;
                check("abort_idle_addr",   ram_addr_o, 32'h0);
                check("abort_inst_held",   if_inst_o,  32'h0000_0513);
                if_addr = 32'h104;
            end
        end
        check("abort_no_done", {31'd0, seen_done}, 32'h0);
        for (int c = 5; c <= 20; c++) begin
            step();
            if (if_done_o) begin
                if_done_at = c;
                data = if_inst_o;
                break;
            end
        end
        if_req = 1'b0;
        step();
        check("abort_refetch_cycle", 32'(if_done_at), 32'd10);
        check("abort_refetch_inst",  data,            32'h0010_0593);

        // Address wrap on a word load.
        run_req(1, 32'hFFFF_FFFE, 32'h0, 2'b10, lat, data, mask, pulse_ok);
        check("wrap_addr0", addr_log[1], 32'hFFFF_FFFE);
        check("wrap_addr1", addr_log[2], 32'hFFFF_FFFF);
        check("wrap_addr2", addr_log[3], 32'h0000_0000);
        check("wrap_addr3", addr_log[4], 32'h0000_0001);
        check("wrap_data",  data,        32'h4433_2211);

        // Reset in the middle of a word store.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h1122_3344; mem_len = 2'b10;
        step(); step();
        rst = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0;
        #1;
        check("mid_rst_ram_we",    {31'd0, ram_we_o},   32'h0);
        check("mid_rst_ram_addr",  ram_addr_o,          32'h0);
        check("mid_rst_ram_dout",  {24'd0, ram_dout_o}, 32'h0);
        check("mid_rst_mem_rdata", mem_rdata_o,         32'h0);
        check("mid_rst_if_inst",   if_inst_o,           32'h0);
        check("mid_rst_dones",     {30'd0, if_done_o, mem_done_o}, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        check("mid_rst_b0", {24'd0, ram_rd(32'h300)}, 32'h44);
        check("mid_rst_b1", {24'd0, ram_rd(32'h301)}, 32'hAA);
        check("mid_rst_b2", {24'd0, ram_rd(32'h302)}, 32'hAA);
        check("mid_rst_b3", {24'd0, ram_rd(32'h303)}, 32'hAA);

        // Random operations against the reference memory.
        for (int i = 0; i < 260; i++) preload(32'h1000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 24; i++) preload(32'hFFFF_FFF8 + 32'(i), 8'($urandom));
        for (int t = 0; t < 80; t++) begin
            int          op;
            int          n;
            logic [1:0]  len;
            logic [31:0] addr;
            logic [31:0] wd;
            op = int'($urandom_range(0, 2));
            len = 2'($urandom_range(0, 3));
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 7));
            else addr = 32'h1000 + 32'($urandom_range(0, 255));
            n = (op == 0) ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
            run_req(op, addr, wd, len, lat, data, mask, pulse_ok);
            check($sformatf("rnd%0d_latency", t), 32'(lat), 32'((op == 2) ? n + 1 : n + 2));
            check($sformatf("rnd%0d_pulse", t), {31'd0, pulse_ok}, 32'h1);
            if (op == 2) begin
                check($sformatf("rnd%0d_we_cycles", t), 32'(mask), 32'(((1 << n) - 1) << 1));
                for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
            end else begin
                check($sformatf("rnd%0d_data", t), data, ref_read(addr, n));
            end
            repeat ($urandom_range(0, 2)) step();
        end
        mism = 0;
        for (int i = 0; i < 260; i++)
            if (ram_rd(32'h1000 + 32'(i)) !== ref_rd(32'h1000 + 32'(i))) mism++;
        for (int i = 0; i < 24; i++)
            if (ram_rd(32'hFFFF_FFF8 + 32'(i)) !== ref_rd(32'hFFFF_FFF8 + 32'(i))) mism++;
        check("rnd_mem_sweep", 32'(mism), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
